// File: rtl/d_flipflop_pkg.sv
// Shared constants for the d_flipflop register slice: default parameters and legal width range.
package d_flipflop_pkg;

    localparam int          DFF_DEFAULT_WIDTH = 1;
    localparam logic [63:0] DFF_DEFAULT_RESET = 64'd0;
    localparam int          DFF_MIN_WIDTH     = 1;
    localparam int          DFF_MAX_WIDTH     = 64;

endpackage

// File: rtl/d_flipflop_cell.sv
// Single-bit register with synchronous active-high reset to its own reset bit.
// Latency one cycle; no backpressure, a new bit is captured on every rising edge.
module d_flipflop_cell #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_BIT;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/d_flipflop.sv
// WIDTH-bit register built from independent single-bit cells; one cycle latency, no backpressure.
// Optional inverted output qn is added when D_FLIPFLOP_QN_EN is defined.
module d_flipflop
    import d_flipflop_pkg::*;
#(
    parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DFF_DEFAULT_RESET)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
`ifdef D_FLIPFLOP_QN_EN
    ,
    output logic [WIDTH-1:0] qn
`endif
);

    if (WIDTH < DFF_MIN_WIDTH || WIDTH > DFF_MAX_WIDTH) begin : g_width_check
        $error("d_flipflop: WIDTH=%0d outside legal range %0d..%0d",
               WIDTH, DFF_MIN_WIDTH, DFF_MAX_WIDTH);
    end

    // Each bit carries its own reset value so RESET_VALUE can be any pattern.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        d_flipflop_cell #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .d     (d[i]),
            .q     (q[i])
        );
    end

`ifdef D_FLIPFLOP_QN_EN
    assign qn = ~q;
`endif

endmodule

// File: tb/tb_d_flipflop.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a monitor pops and compares after each edge.
module tb_d_flipflop;

    logic       clk = 1'b0;
    logic       reset1;
    logic [0:0] d1;
    logic [0:0] q1;
    logic       reset8;
    logic [7:0] d8;
    logic [7:0] q8;
`ifdef D_FLIPFLOP_QN_EN
    logic [0:0] qn1;
    logic [7:0] qn8;
`endif

    always #5 clk = ~clk;

    d_flipflop #(
        .WIDTH       (1),
        .RESET_VALUE (1'b0)
    ) dut1 (
        .clk   (clk),
        .reset (reset1),
        .d     (d1),
`ifdef D_FLIPFLOP_QN_EN
        .qn    (qn1),
`endif
        .q     (q1)
    );

    d_flipflop #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) dut8 (
        .clk   (clk),
        .reset (reset8),
        .d     (d8),
`ifdef D_FLIPFLOP_QN_EN
        .qn    (qn8),
`endif
        .q     (q8)
    );

    typedef struct packed {
        logic       r1;
        logic       d1;
        logic       e1;
        logic       r8;
        logic [7:0] d8;
        logic [7:0] e8;
    } vec_t;

    typedef struct packed {
        logic       e1;
        logic [7:0] e8;
    } exp_t;

    localparam int NVEC = 8;

    vec_t vecs [NVEC];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: sample 2 ns after each rising edge, then re-check 6 ns later
    // (after the inputs have moved) to confirm q held its value.
    initial begin
        exp_t cur;
        bit   have;
        have = 1'b0;
        cur  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                cur  = sb.pop_front();
                have = 1'b1;
                check("q_w1", {7'd0, q1}, {7'd0, cur.e1});
                check("q_w8", q8, cur.e8);
`ifdef D_FLIPFLOP_QN_EN
                check("qn_w1", {7'd0, qn1}, {7'd0, ~cur.e1});
                check("qn_w8", qn8, ~cur.e8);
`endif
            end
            #6;
            if (have) begin
                check("hold_w1", {7'd0, q1}, {7'd0, cur.e1});
                check("hold_w8", q8, cur.e8);
            end
        end
    end

    initial begin
        //            r1    d1    e1    r8    d8     e8
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 8'hA5};  // t=0   reset, d ignored
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 8'h3C};  // t=10
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 8'hC3};  // t=20
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hA5};  // t=30
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h3C};  // t=40  reset wins over d=1
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};  // t=50  no recovery cycle
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 8'hA5};  // t=60
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h81, 8'h81};  // t=70

        for (int i = 0; i < NVEC; i++) begin
            if (i > 0) @(negedge clk);
            reset1 = vecs[i].r1;
            d1     = vecs[i].d1;
            reset8 = vecs[i].r8;
            d8     = vecs[i].d8;
            sb.push_back('{vecs[i].e1, vecs[i].e8});
        end

        for (int n = 0; n < 10 && sb.size() > 0; n++) @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
